// File: rtl/csi2_pkg.sv
// CSI-2 packet sequencer shared definitions.
// Holds the packet data types, the sequencer states and the frame-number wrap rule.
package csi2_pkg;

    localparam logic [5:0] DT_FS       = 6'h00;
    localparam logic [5:0] DT_FE       = 6'h01;
    localparam logic [5:0] DT_YUV422_8 = 6'h1E;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_SEND_FS,
        S_WAIT_LINE,
        S_SEND_LH,
        S_LINE,
        S_SEND_FE,
        S_GAP
    } state_e;

    // Frame numbers run 1..65535; zero is reserved for "no frame yet".
    function automatic logic [15:0] next_frame(input logic [15:0] f);
        return (f == 16'hFFFF) ? 16'd1 : f + 16'd1;
    endfunction

endpackage

// File: rtl/csi2_edge_sync.sv
// Registers FV/LV once and derives single-cycle edge pulses from the registered copies.
// Ports: i_clk, i_rst_n, i_fv, i_lv in; o_fv, o_lv levels, o_fv_rise, o_lv_rise, o_lv_fall pulses out.
module csi2_edge_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_fv,
    input  logic i_lv,
    output logic o_fv,
    output logic o_lv,
    output logic o_fv_rise,
    output logic o_lv_rise,
    output logic o_lv_fall
);

    logic r_fv;
    logic r_lv;
    logic r_fv_d;
    logic r_lv_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fv   <= 1'b0;
            r_lv   <= 1'b0;
            r_fv_d <= 1'b0;
            r_lv_d <= 1'b0;
        end else begin
            r_fv   <= i_fv;
            r_lv   <= i_lv;
            r_fv_d <= r_fv;
            r_lv_d <= r_lv;
        end
    end

    assign o_fv      = r_fv;
    assign o_lv      = r_lv;
    assign o_fv_rise = r_fv & ~r_fv_d;
    assign o_lv_rise = r_lv & ~r_lv_d;
    assign o_lv_fall = r_lv_d & ~r_lv;

endmodule

// File: rtl/csi2_pkt_sequencer.sv
// Turns FV/LV edges into ordered CSI-2 requests (FS, line headers, FE) with HS lead/LP gap timing.
// Ports: clock_in, reset_n, fv, lv, pkt_ack in; pkt_* request bundle, data_gate, hs_en, frame_num, line_cnt, err_* out.
module csi2_pkt_sequencer
    import csi2_pkg::*;
#(
    parameter logic [1:0]  VC         = 2'd0,
    parameter logic [5:0]  DT_DATA    = DT_YUV422_8,
    parameter logic [15:0] WORD_COUNT = 16'd1280,
    parameter logic [9:0]  LINES      = 10'd480,
    parameter logic [7:0]  HS_LEAD    = 8'd16,
    parameter logic [7:0]  LP_GAP     = 8'd32
) (
    input  logic        clock_in,
    input  logic        reset_n,
    input  logic        fv,
    input  logic        lv,
    input  logic        pkt_ack,
    output logic        pkt_req,
    output logic        pkt_long,
    output logic [5:0]  pkt_dt,
    output logic [1:0]  pkt_vc,
    output logic [15:0] pkt_wc,
    output logic        data_gate,
    output logic        hs_en,
    output logic [15:0] frame_num,
    output logic [9:0]  line_cnt,
    output logic        err_sync,
    output logic        err_len
);

    state_e      r_state;
    state_e      w_state_n;
    logic [7:0]  r_cnt;
    logic [11:0] r_pix;
    logic [9:0]  r_line;
    logic [15:0] r_frame_num;
    logic        r_fv_pend;
    logic        r_err_sync;
    logic        r_err_len;

    logic        w_fv;
    logic        w_lv;
    logic        w_fv_rise;
    logic        w_lv_rise;
    logic        w_lv_fall;
    logic        w_take;
    logic        w_drop;
    logic        w_in_line;
    logic        w_cut;
    logic        w_start;
    logic        w_req_state;
    logic [15:0] w_pix16;

    csi2_edge_sync u_sync (
        .i_clk     (clock_in),
        .i_rst_n   (reset_n),
        .i_fv      (fv),
        .i_lv      (lv),
        .o_fv      (w_fv),
        .o_lv      (w_lv),
        .o_fv_rise (w_fv_rise),
        .o_lv_rise (w_lv_rise),
        .o_lv_fall (w_lv_fall)
    );

    assign w_pix16     = {4'd0, r_pix};
    assign w_in_line   = (r_state == S_SEND_LH) || (r_state == S_LINE);
    assign w_cut       = w_in_line && w_lv && (w_pix16 == WORD_COUNT);
    assign w_start     = (w_state_n == S_LEAD) && (r_state != S_LEAD);
    assign w_req_state = (r_state == S_SEND_FS) || (r_state == S_SEND_LH) ||
                         (r_state == S_SEND_FE);

    always_comb begin
        w_state_n = r_state;
        w_take    = 1'b0;
        w_drop    = 1'b0;
        unique case (r_state)
            S_IDLE:      if (w_fv_rise) w_state_n = S_LEAD;
            S_LEAD:      if (r_cnt == HS_LEAD - 8'd1) w_state_n = S_SEND_FS;
            S_SEND_FS:   if (pkt_ack) w_state_n = S_WAIT_LINE;
            S_WAIT_LINE: begin
                // FV fall wins; a line that would start now is outside the frame.
                if (!w_fv) begin
                    w_state_n = S_SEND_FE;
                end else if (w_lv_rise) begin
                    if (r_line < LINES) begin
                        w_take    = 1'b1;
                        w_state_n = S_SEND_LH;
                    end else begin
                        w_drop = 1'b1;
                    end
                end
            end
            S_SEND_LH:   if (pkt_ack) w_state_n = S_LINE;
            S_LINE:      if (!w_lv) w_state_n = S_WAIT_LINE;
            S_SEND_FE:   if (pkt_ack) w_state_n = S_GAP;
            S_GAP: begin
                if (r_cnt == LP_GAP - 8'd1)
                    w_state_n = (r_fv_pend || w_fv_rise) ? S_LEAD : S_IDLE;
            end
            default:     w_state_n = S_IDLE;
        endcase
    end

    always_comb begin
        pkt_req  = w_req_state;
        pkt_long = 1'b0;
        pkt_dt   = 6'd0;
        pkt_vc   = 2'd0;
        pkt_wc   = 16'd0;
        unique case (r_state)
            S_SEND_FS: begin
                pkt_dt = DT_FS;
                pkt_vc = VC;
                pkt_wc = r_frame_num;
            end
            S_SEND_LH: begin
                pkt_long = 1'b1;
                pkt_dt   = DT_DATA;
                pkt_vc   = VC;
                pkt_wc   = WORD_COUNT;
            end
            S_SEND_FE: begin
                pkt_dt = DT_FE;
                pkt_vc = VC;
                pkt_wc = r_frame_num;
            end
            default: ;
        endcase
    end

    // Gate opens on the accepted LV-rise cycle and closes after WORD_COUNT bytes.
    assign data_gate = w_take || (w_in_line && w_lv && (w_pix16 < WORD_COUNT));
    assign hs_en     = (r_state != S_IDLE) && (r_state != S_GAP);
    assign frame_num = r_frame_num;
    assign line_cnt  = r_line;
    assign err_sync  = r_err_sync;
    assign err_len   = r_err_len;

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_n;
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt       <= 8'd0;
            r_pix       <= 12'd0;
            r_line      <= 10'd0;
            r_frame_num <= 16'd0;
            r_fv_pend   <= 1'b0;
            r_err_sync  <= 1'b0;
            r_err_len   <= 1'b0;
        end else begin
            r_cnt <= (w_state_n != r_state) ? 8'd0 : r_cnt + 8'd1;

            if (w_start) begin
                r_frame_num <= next_frame(r_frame_num);
                r_line      <= 10'd0;
            end else if (w_lv_fall && w_in_line) begin
                r_line <= r_line + 10'd1;
            end

            if (w_start)
                r_fv_pend <= 1'b0;
            else if (w_fv_rise && (r_state == S_SEND_FE || r_state == S_GAP))
                r_fv_pend <= 1'b1;

            if (w_take)
                r_pix <= 12'd1;
            else if (w_in_line && data_gate)
                r_pix <= r_pix + 12'd1;

            if (w_drop || w_cut ||
                (w_lv_fall && w_in_line && (w_pix16 != WORD_COUNT)))
                r_err_len <= 1'b1;

            if ((w_lv_rise && w_req_state) || (w_lv && !w_fv))
                r_err_sync <= 1'b1;
        end
    end

endmodule
